// File: rtl/io_seq_pkg.sv
// Shared register map, bit positions and sequencer state encoding for the
// GPIO pattern sequencer.
package io_seq_pkg;

  localparam logic [7:0] OFS_CTRL     = 8'h00;
  localparam logic [7:0] OFS_STATUS   = 8'h04;
  localparam logic [7:0] OFS_HOLD     = 8'h08;
  localparam logic [7:0] OFS_PAT_BASE = 8'h40;

  localparam int CTRL_START   = 0;
  localparam int CTRL_LOOP    = 1;
  localparam int CTRL_OE_EN   = 2;
  localparam int CTRL_ABORT   = 3;
  localparam int CTRL_LEN_LSB = 4;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IDX_LSB = 4;

  // Step index and LEN are always 4 bits; DEPTH never exceeds 16.
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/io_seq_wb_regs.sv
// Wishbone slave for the sequencer: decode, single-cycle ack, config
// registers, pattern RAM and registered readback.
module io_seq_wb_regs
  import io_seq_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          DEPTH     = 16,
  parameter int          HOLD_W    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stb,
  input  logic              i_cyc,
  input  logic              i_we,
  input  logic [3:0]        i_sel,
  input  logic [31:0]       i_adr,
  input  logic [31:0]       i_dat,
  output logic              o_ack,
  output logic [31:0]       o_dat,
  input  logic              i_busy,
  input  logic              i_done,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [IDX_W-1:0]  i_pat_idx,
  output logic [WIDTH-1:0]  o_pat_data,
  output logic              o_start,
  output logic              o_abort,
  output logic              o_done_clr,
  output logic              o_loop,
  output logic              o_oe_en,
  output logic [IDX_W-1:0]  o_len,
  output logic [HOLD_W-1:0] o_hold
);

  localparam logic [IDX_W-1:0] LEN_MAX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   DEPTH_X = (IDX_W + 1)'(DEPTH);

  logic              r_ack;
  logic [31:0]       r_dat;
  logic              r_loop;
  logic              r_oe_en;
  logic [IDX_W-1:0]  r_len;
  logic [HOLD_W-1:0] r_hold;
  logic [WIDTH-1:0]  r_pat [DEPTH];

  logic              w_hit;
  logic              w_access;
  logic              w_wr;
  logic              w_ctrl_wr;
  logic              w_pat_sel;
  logic [7:0]        w_ofs;
  logic [IDX_W-1:0]  w_pat_idx;
  logic [IDX_W-1:0]  w_len_in;
  logic [IDX_W-1:0]  w_len_clamped;
  logic [31:0]       w_rdata;
  logic              w_unused;

  // One access per hit: the cycle that raises ack performs the write/read.
  assign w_hit     = i_stb & i_cyc & (i_adr[31:8] == BASE_ADDR[31:8]);
  assign w_access  = w_hit & ~r_ack;
  assign w_wr      = w_access & i_we;
  assign w_ofs     = {i_adr[7:2], 2'b00};
  assign w_pat_idx = i_adr[5:2];
  assign w_pat_sel = (i_adr[7:6] == OFS_PAT_BASE[7:6]) && ({1'b0, w_pat_idx} < DEPTH_X);
  assign w_ctrl_wr = w_wr & i_sel[0] & (w_ofs == OFS_CTRL);

  assign w_len_in      = i_dat[CTRL_LEN_LSB +: IDX_W];
  assign w_len_clamped = ({1'b0, w_len_in} > {1'b0, LEN_MAX}) ? LEN_MAX : w_len_in;

  assign o_start    = w_ctrl_wr & i_dat[CTRL_START];
  assign o_abort    = w_ctrl_wr & i_dat[CTRL_ABORT];
  assign o_done_clr = w_wr & i_sel[0] & (w_ofs == OFS_STATUS) & i_dat[STAT_DONE];
  assign o_ack      = r_ack;
  assign o_dat      = r_dat;
  assign o_loop     = r_loop;
  assign o_oe_en    = r_oe_en;
  assign o_len      = r_len;
  assign o_hold     = r_hold;
  assign o_pat_data = r_pat[i_pat_idx];
  assign w_unused   = ^{i_adr[1:0], i_dat[31:16], i_sel[3:2]};

  always_comb begin
    w_rdata = '0;
    if (w_pat_sel) begin
      w_rdata[WIDTH-1:0] = r_pat[w_pat_idx];
    end else begin
      case (w_ofs)
        OFS_CTRL: begin
          w_rdata[CTRL_LOOP]                = r_loop;
          w_rdata[CTRL_OE_EN]               = r_oe_en;
          w_rdata[CTRL_LEN_LSB +: IDX_W]    = r_len;
        end
        OFS_STATUS: begin
          w_rdata[STAT_BUSY]                = i_busy;
          w_rdata[STAT_DONE]                = i_done;
          w_rdata[STAT_IDX_LSB +: IDX_W]    = i_idx;
        end
        OFS_HOLD: w_rdata[HOLD_W-1:0] = r_hold;
        default:  w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_loop  <= 1'b0;
      r_oe_en <= 1'b0;
      r_len   <= '0;
      r_hold  <= '0;
      for (int i = 0; i < DEPTH; i++) r_pat[i] <= '0;
    end else begin
      r_ack <= w_hit & ~r_ack;
      r_dat <= w_access ? w_rdata : '0;
      if (w_ctrl_wr) begin
        r_loop  <= i_dat[CTRL_LOOP];
        r_oe_en <= i_dat[CTRL_OE_EN];
        r_len   <= w_len_clamped;
      end
      if (w_wr && (w_ofs == OFS_HOLD)) begin
        for (int k = 0; k < HOLD_W; k++) if (i_sel[k/8]) r_hold[k] <= i_dat[k];
      end
      if (w_wr && w_pat_sel) begin
        for (int k = 0; k < WIDTH; k++) if (i_sel[k/8]) r_pat[w_pat_idx][k] <= i_dat[k];
      end
    end
  end

endmodule

// File: rtl/io_pattern_seq.sv
// GPIO pattern sequencer: steps io_out through programmed patterns, each held
// HOLD+1 cycles, optionally looping, with a done pulse on one-shot completion.
module io_pattern_seq
  import io_seq_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          DEPTH     = 16,
  parameter int          HOLD_W    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oeb,
  output logic             irq
);

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt, w_load_idx;
  logic [HOLD_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]  r_out;
  logic              r_done, w_done_nxt;
  logic              r_irq, w_irq_nxt;
  logic              w_load;

  logic              w_start, w_abort, w_done_clr, w_loop, w_oe_en;
  logic [IDX_W-1:0]  w_len;
  logic [HOLD_W-1:0] w_hold;
  logic [WIDTH-1:0]  w_pat_data;

  io_seq_wb_regs #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .BASE_ADDR(BASE_ADDR)
  ) u_regs (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_stb      (wbs_stb_i),
    .i_cyc      (wbs_cyc_i),
    .i_we       (wbs_we_i),
    .i_sel      (wbs_sel_i),
    .i_adr      (wbs_adr_i),
    .i_dat      (wbs_dat_i),
    .o_ack      (wbs_ack_o),
    .o_dat      (wbs_dat_o),
    .i_busy     (r_state == RUN),
    .i_done     (r_done),
    .i_idx      (r_idx),
    .i_pat_idx  (w_load_idx),
    .o_pat_data (w_pat_data),
    .o_start    (w_start),
    .o_abort    (w_abort),
    .o_done_clr (w_done_clr),
    .o_loop     (w_loop),
    .o_oe_en    (w_oe_en),
    .o_len      (w_len),
    .o_hold     (w_hold)
  );

  assign io_out = r_out;
  assign io_oeb = {WIDTH{~w_oe_en}};
  assign irq    = r_irq;

  // ABORT overrides everything, including a START in the same write.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = r_done;
    w_irq_nxt   = 1'b0;
    w_load      = 1'b0;
    w_load_idx  = '0;
    if (w_done_clr) w_done_nxt = 1'b0;
    if (w_abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            w_state_nxt = RUN;
            w_idx_nxt   = '0;
            w_cnt_nxt   = w_hold;
            w_done_nxt  = 1'b0;
            w_load      = 1'b1;
          end
        end
        RUN: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - {{(HOLD_W-1){1'b0}}, 1'b1};
          end else if (r_idx != w_len) begin
            w_idx_nxt  = r_idx + 4'd1;
            w_load_idx = r_idx + 4'd1;
            w_cnt_nxt  = w_hold;
            w_load     = 1'b1;
          end else if (w_loop) begin
            w_idx_nxt  = '0;
            w_cnt_nxt  = w_hold;
            w_load     = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
            w_irq_nxt   = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_irq   <= w_irq_nxt;
      if (w_load) r_out <= w_pat_data;
    end
  end

endmodule

// File: tb/tb_io_pattern_seq.sv
// Directed bench for io_pattern_seq: Wishbone programming, step timing,
// loop/abort, decode boundaries and mid-run reset.
module tb_io_pattern_seq;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_HOLD = BASE + 32'h08;
  localparam logic [31:0] A_PAT  = BASE + 32'h40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  io_out;
  logic [7:0]  io_oeb;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  io_pattern_seq dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq       (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic got, output logic [31:0] rd);
    got = 1'b0;
    rd  = '0;
    adr = a; we = w; wdat = d; sel = s; stb = 1'b1; cyc = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (ack) begin
        got = 1'b1;
        rd  = rdat;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic got;
    logic [31:0] rd;
    wb_access(a, 1'b1, d, s, got, rd);
    check("wr_ack", {31'b0, got}, 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    logic got;
    wb_access(a, 1'b0, '0, 4'hF, got, d);
    check("rd_ack", {31'b0, got}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        got;
    logic [7:0]  seq [12];
    logic [7:0]  p4 [4];
    logic [7:0]  q8 [8];
    int          irq_cnt;

    // reset
    rst = 1'b1;
    repeat (3) tick();
    check("rst_io_out", {24'b0, io_out}, 32'h00);
    check("rst_io_oeb", {24'b0, io_oeb}, 32'hFF);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    rst = 1'b0;
    tick();
    wb_read(A_STAT, rd);
    check("rst_status", rd, 32'h0);

    // one-shot 12-step sequence, HOLD=3
    for (int i = 0; i < 10; i++) seq[i] = 8'(i + 1);
    seq[10] = 8'hFF;
    seq[11] = 8'h00;
    for (int i = 0; i < 12; i++) wb_write(A_PAT + 32'(4 * i), {24'b0, seq[i]}, 4'hF);
    wb_write(A_HOLD, 32'd3, 4'hF);
    wb_write(A_CTRL, 32'hB4, 4'h1);
    check("oe_enabled", {24'b0, io_oeb}, 32'h00);
    wb_read(A_PAT + 32'd40, rd);
    check("pat10_read", rd, 32'hFF);
    wb_write(A_CTRL, 32'hB5, 4'h1);
    irq_cnt = 0;
    for (int t = 0; t < 48; t++) begin
      check("seq_out", {24'b0, io_out}, {24'b0, seq[t/4]});
      irq_cnt += int'(irq);
      tick();
    end
    check("seq_irq_at_48", {31'b0, irq}, 32'd1);
    check("seq_last_held", {24'b0, io_out}, 32'h00);
    irq_cnt += int'(irq);
    tick();
    irq_cnt += int'(irq);
    check("seq_irq_count", 32'(irq_cnt), 32'd1);
    wb_read(A_STAT, rd);
    check("seq_status", rd, 32'hB2);

    // loop 55/AA with HOLD=0, then abort
    wb_write(A_PAT + 32'd0, 32'h55, 4'hF);
    wb_write(A_PAT + 32'd4, 32'hAA, 4'hF);
    wb_write(A_HOLD, 32'd0, 4'hF);
    wb_write(A_CTRL, 32'h17, 4'h1);
    irq_cnt = 0;
    for (int t = 0; t < 8; t++) begin
      check("loop_out", {24'b0, io_out}, (t % 2 == 1) ? 32'hAA : 32'h55);
      irq_cnt += int'(irq);
      tick();
    end
    check("loop_no_irq", 32'(irq_cnt), 32'd0);
    check("loop_pre_abort", {24'b0, io_out}, 32'h55);
    wb_write(A_CTRL, 32'h1E, 4'h1);
    check("abort_frozen", {24'b0, io_out}, 32'h55);
    repeat (3) tick();
    check("abort_still", {24'b0, io_out}, 32'h55);
    check("abort_no_irq", {31'b0, irq}, 32'd0);
    wb_read(A_STAT, rd);
    check("abort_status", rd, 32'h00);
    wb_read(A_CTRL, rd);
    check("ctrl_readback", rd, 32'h16);

    // Wishbone decode and byte selects
    wb_write(A_HOLD, 32'hFFFF, 4'b0001);
    wb_read(A_HOLD, rd);
    check("hold_sel_byte0", rd, 32'hFF);
    wb_write(BASE + 32'h20, 32'hDEAD_BEEF, 4'hF);
    wb_read(BASE + 32'h20, rd);
    check("unmapped_reads0", rd, 32'h0);
    wb_access(32'h3100_0000, 1'b0, '0, 4'hF, got, rd);
    check("miss_no_ack", {31'b0, got}, 32'd0);
    wb_access(32'h3100_0008, 1'b1, 32'h1234, 4'hF, got, rd);
    check("miss_wr_no_ack", {31'b0, got}, 32'd0);
    wb_read(A_HOLD, rd);
    check("miss_wr_ignored", rd, 32'hFF);

    // START during RUN is ignored
    p4[0] = 8'h11; p4[1] = 8'h22; p4[2] = 8'h33; p4[3] = 8'h44;
    for (int i = 0; i < 4; i++) wb_write(A_PAT + 32'(4 * i), {24'b0, p4[i]}, 4'hF);
    wb_write(A_HOLD, 32'd1, 4'b0011);
    wb_write(A_CTRL, 32'h35, 4'h1);
    for (int t = 0; t < 8; t++) begin
      check("restart_out", {24'b0, io_out}, {24'b0, p4[t/2]});
      if (t == 3) wb_write(A_CTRL, 32'h35, 4'h1);
      else tick();
    end
    check("restart_irq", {31'b0, irq}, 32'd1);
    check("restart_last", {24'b0, io_out}, 32'h44);

    // START+ABORT together: stays idle, DONE kept; then clear DONE
    wb_write(A_CTRL, 32'h3D, 4'h1);
    check("startabort_out", {24'b0, io_out}, 32'h44);
    tick();
    check("startabort_hold", {24'b0, io_out}, 32'h44);
    wb_read(A_STAT, rd);
    check("startabort_status", rd, 32'h32);
    wb_write(A_STAT, 32'h2, 4'h1);
    wb_read(A_STAT, rd);
    check("done_clear", rd, 32'h30);

    // reset mid-run at step 5
    for (int i = 0; i < 8; i++) q8[i] = 8'(8'hC0 + i);
    for (int i = 0; i < 8; i++) wb_write(A_PAT + 32'(4 * i), {24'b0, q8[i]}, 4'hF);
    wb_write(A_HOLD, 32'd0, 4'hF);
    wb_write(A_CTRL, 32'h75, 4'h1);
    for (int t = 0; t < 5; t++) begin
      check("midrst_out", {24'b0, io_out}, {24'b0, q8[t]});
      tick();
    end
    check("midrst_step5", {24'b0, io_out}, {24'b0, q8[5]});
    rst = 1'b1;
    tick();
    check("midrst_io_out", {24'b0, io_out}, 32'h00);
    check("midrst_io_oeb", {24'b0, io_oeb}, 32'hFF);
    check("midrst_irq", {31'b0, irq}, 32'd0);
    rst = 1'b0;
    tick();
    wb_read(A_STAT, rd);
    check("midrst_status", rd, 32'h0);
    wb_read(A_PAT, rd);
    check("midrst_pat0", rd, 32'h0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_pattern_seq.md
Name: io_pattern_seq

Overview:
Wishbone-programmable output pattern sequencer for the user-project GPIO pads (mprj_io lower byte).
- Firmware loads up to DEPTH patterns and a hold count, then starts the sequence.
- The block drives io_out/io_oeb step by step, optionally looping, and pulses irq when a one-shot sequence completes.
- Sits in user_project_wrapper between the Wishbone slave port and the mprj_io output/OEB buses.

Parameters:
- WIDTH, 8, number of driven IO pins.
- DEPTH, 16, pattern slots; power of two, at most 16.
- HOLD_W, 16, width of the hold counter.
- BASE_ADDR, 32'h3000_0000, Wishbone base; decode on bits [31:8].

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- io_out  out  WIDTH  pad output values.
- io_oeb  out  WIDTH  pad output enables, active-low.
- irq  out  1  one-cycle done pulse.

Behaviour:
- Reset values: io_out=0, io_oeb all 1, wbs_ack_o=0, wbs_dat_o=0, irq=0, all registers 0, state IDLE.
- Decode: hit when stb&cyc&(adr[31:8]==BASE_ADDR[31:8]).
  - wbs_ack_o asserts the cycle after a hit, for exactly one cycle; it is not reasserted while already high.
  - Misses get no ack.
  - Unmapped offsets inside the window are acked, read 0, and ignore writes.
  - Writes honour wbs_sel_i per byte. Read data is registered and valid with ack.
- Registers (byte offset):
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bit1 LOOP, bit2 OE_EN, bit3 ABORT (write-1 pulse, reads 0), bits[7:4] LEN, giving sequence length LEN+1 (values > DEPTH-1 clamp to DEPTH-1).
  - 0x04 STATUS (RO): bit0 BUSY, bit1 DONE (sticky; cleared by START or a write of 1 to bit1), bits[7:4] current index.
  - 0x08 HOLD: bits[HOLD_W-1:0].
  - 0x40+4*i PAT[i]: bits[WIDTH-1:0].
- io_oeb = {WIDTH{~OE_EN}}, updated the cycle after the CTRL write. io_out is driven regardless of OE_EN.
- FSM IDLE:
  - START while IDLE: next edge io_out=PAT[0], idx=0, cnt=HOLD, DONE=0, state RUN.
  - START while RUN is ignored.
- FSM RUN, each cycle:
  - If cnt!=0: cnt-1.
  - Else if idx!=LEN: idx+1, io_out=PAT[idx+1], cnt=HOLD.
  - Else if LOOP: idx=0, io_out=PAT[0], cnt=HOLD.
  - Else: state IDLE, DONE=1, irq=1 for one cycle, io_out holds the last pattern.
- Each step is visible for exactly HOLD+1 cycles. HOLD=0 gives a new pattern every cycle.
- ABORT, any state: next edge IDLE, io_out holds its current value, DONE unchanged, no irq. ABORT and START in the same write: ABORT wins.
- Writes to PAT, HOLD, LEN or LOOP during RUN take effect at the next step load or end check; no restart.
- Clearing LOOP mid-run ends the sequence at the next idx==LEN boundary.
- wb_rst_i mid-run returns every output to its reset value on the next edge.

Decomposition:
- Package io_seq_pkg holds:
  - register offsets (CTRL, STATUS, HOLD, PAT_BASE);
  - CTRL/STATUS bit positions;
  - the state enum {IDLE, RUN}.
- Sub-module io_seq_wb_regs: Wishbone decode, ack, register file, PAT array and readback. It exports start/abort pulses and config values to the FSM and counter in io_pattern_seq.

Test Plan:
- Reset: hold wb_rst_i 3 cycles -> io_out=8'h00, io_oeb=8'hFF, ack=0, irq=0; STATUS reads 0.
- Program PAT[0..11]=01..0A,FF,00, HOLD=3, CTRL=0xB4 (LEN=11, OE_EN, no loop), then START -> io_oeb=8'h00. io_out steps through 01..0A,FF,00, 4 cycles each; irq pulses once 48 cycles after the first load; STATUS=0xB2.
- LOOP=1, LEN=1, PAT0=0x55, PAT1=0xAA, HOLD=0 -> io_out alternates 55/AA every cycle, no irq. ABORT -> io_out frozen, BUSY=0.
- Wishbone: sel=4'b0001 write 0xFFFF to HOLD -> HOLD reads 0x00FF. Access at offset 0x20 -> ack, reads 0. Address 0x3100_0000 -> no ack.
- START during RUN -> ignored, step order unchanged. START+ABORT in one write -> IDLE, no output change.
- wb_rst_i asserted mid-run at step 5 -> next edge io_out=0, io_oeb=FF, STATUS=0.
